// File: rtl/score_accumulator.sv
// Multi-digit BCD score accumulator: digit-serial addition with decimal carry,
// saturation at all nines, high-score tracking and a registered seven-segment bank.
module score_accumulator #(
    parameter int SCORE_DIGITS  = 6,
    parameter int ADD_DIGITS    = 2,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [4*ADD_DIGITS-1:0]   addend,
    input  logic                      clearScore,
    input  logic                      showHigh,
    output logic                      ready,
    output logic                      error,
    output logic                      overflow,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] highScore,
    output logic [7*SCORE_DIGITS-1:0] display
);

    localparam int IDX_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
    localparam logic [4*SCORE_DIGITS-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        COMMIT
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      carry_q, carry_d;
    logic [4*SCORE_DIGITS-1:0] addend_q, addend_d;
    logic [4*SCORE_DIGITS-1:0] work_q, work_d;
    logic [4*SCORE_DIGITS-1:0] score_q, score_d;
    logic [4*SCORE_DIGITS-1:0] high_q, high_d;
    logic                      overflow_q, overflow_d;
    logic                      error_q, error_d;
    logic [7*SCORE_DIGITS-1:0] display_q, display_d;

    logic                      accept;
    logic                      addend_bad;
    logic [3:0]                cur_score;
    logic [3:0]                cur_add;
    logic [4:0]                digit_sum;
    logic [3:0]                digit_res;
    logic [4*SCORE_DIGITS-1:0] commit_score;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Walk from the top digit down; everything above the first nonzero digit is leading.
    function automatic logic [7*SCORE_DIGITS-1:0] render(input logic [4*SCORE_DIGITS-1:0] value);
        logic [7*SCORE_DIGITS-1:0] segs;
        logic                      leading;
        segs    = '0;
        leading = 1'b1;
        for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
            if (value[4*i +: 4] != 4'd0) leading = 1'b0;
            if (BLANK_LEADING && leading && i != 0) segs[7*i +: 7] = 7'h7F;
            else                                    segs[7*i +: 7] = seg7(value[4*i +: 4]);
        end
        return segs;
    endfunction

    assign ready  = (state_q == IDLE);
    assign accept = enable & ready & ~clearScore;

    always_comb begin
        cur_score = '0;
        cur_add   = '0;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_score = score_q[4*i +: 4];
                cur_add   = addend_q[4*i +: 4];
            end
        end
        digit_sum = {1'b0, cur_score} + {1'b0, cur_add} + {4'd0, carry_q};
        digit_res = (digit_sum > 5'd9) ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
        commit_score = carry_q ? ALL_NINES : work_q;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        addend_d   = addend_q;
        work_d     = work_q;
        score_d    = score_q;
        high_d     = high_q;
        overflow_d = overflow_q;
        error_d    = 1'b0;
        addend_bad = 1'b0;

        for (int i = 0; i < ADD_DIGITS; i++) begin
            if (addend[4*i +: 4] > 4'd9) addend_bad = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addend_bad) begin
                        error_d = 1'b1;
                    end else begin
                        addend_d = (4*SCORE_DIGITS)'(addend);
                        idx_d    = '0;
                        carry_d  = 1'b0;
                        state_d  = ADD;
                    end
                end
            end
            ADD: begin
                for (int i = 0; i < SCORE_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) work_d[4*i +: 4] = digit_res;
                end
                carry_d = (digit_sum > 5'd9);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(SCORE_DIGITS - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                score_d    = commit_score;
                overflow_d = overflow_q | carry_q;
                if (commit_score > high_q) high_d = commit_score;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A clear aborts any in-flight add without committing it.
        if (clearScore) begin
            state_d    = IDLE;
            score_d    = '0;
            high_d     = high_q;
            overflow_d = 1'b0;
        end
    end

    assign display_d = render(showHigh ? high_q : score_q);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            addend_q   <= '0;
            work_q     <= '0;
            score_q    <= '0;
            high_q     <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
            display_q  <= render('0);
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            addend_q   <= addend_d;
            work_q     <= work_d;
            score_q    <= score_d;
            high_q     <= high_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
            display_q  <= display_d;
        end
    end

    assign error     = error_q;
    assign overflow  = overflow_q;
    assign score     = score_q;
    assign highScore = high_q;
    assign display   = display_q;

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
Parametrised successor to the single-increment score counter. It accepts a multi-digit BCD addend through a ready/enable handshake and adds it to a SCORE_DIGITS-wide BCD score, one digit per clock, with decimal carry. The score saturates at all-nines, a high score is tracked, and the block drives the DE1-SoC seven-segment bank directly with either score or high score, with optional leading-zero blanking.

Parameters:
SCORE_DIGITS, 6, number of BCD digits in score, high score and display (1..8)
ADD_DIGITS, 2, number of BCD digits in addend (1..SCORE_DIGITS)
BLANK_LEADING, 1, 1 = blank leading zero digits on display; digit 0 is never blanked

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-low reset
enable  input  1  add request; accepted only when ready=1 and clearScore=0
addend  input  4*ADD_DIGITS  BCD addend, digit 0 in bits [3:0]; sampled on accept
clearScore  input  1  synchronous score clear; high score kept
showHigh  input  1  0 = display score, 1 = display high score
ready  output  1  1 = idle, a request can be accepted
error  output  1  one-cycle pulse: request rejected, addend digit > 9
overflow  output  1  sticky: a saturating add occurred since last clear/reset
score  output  4*SCORE_DIGITS  current BCD score
highScore  output  4*SCORE_DIGITS  highest committed score since reset
display  output  7*SCORE_DIGITS  active-low segments, 7 bits per digit {g,f,e,d,c,b,a}, digit 0 in [6:0]

Behaviour:
- Reset (reset=0 at clock edge): state IDLE, ready=1, error=0, overflow=0, score=0, highScore=0, display = all digits showing "0" (or digits 1..N-1 blanked to 7'h7F and digit 0 = "0" when BLANK_LEADING=1).
- FSM states: IDLE, ADD, COMMIT.
- IDLE: ready=1. accept = enable & ready & ~clearScore. On accept with all addend digits <= 9: latch addend zero-extended to SCORE_DIGITS, digit index=0, carry=0, -> ADD. On accept with any digit > 9: error=1 for one cycle, stay IDLE, score unchanged.
- ADD: one digit per cycle: s = score[i] + addend[i] + carry; if s > 9 then digit = s-10, carry=1, else digit = s, carry=0. Results go to a working register; score is not updated mid-add. After digit SCORE_DIGITS-1 -> COMMIT. ready=0.
- COMMIT: if final carry=1, score <= all 9s and overflow <= 1; otherwise score <= working result. In the same cycle highScore <= new score if new score > highScore (BCD compare equals unsigned compare). -> IDLE.
- Latency: accept at edge N; score/highScore valid after edge N+SCORE_DIGITS+1; ready=1 again in that cycle. Back-to-back: a new accept is possible in the first IDLE cycle.
- Already saturated score plus any nonzero addend stays all 9s; addend 0 leaves score unchanged and does not alter overflow.
- clearScore: takes priority in every state. Score and overflow go to 0 at the next edge. An in-flight add is aborted (no commit), state -> IDLE. highScore is unchanged. enable together with clearScore is not accepted.
- Reset mid-operation: same as the reset values above; the in-flight add is lost.
- Display: registered, 1 cycle after score/highScore/showHigh change. Digit patterns 0-9 are standard active-low. Blanked digit = 7'h7F. With BLANK_LEADING=1, every digit above the most significant nonzero digit is blanked; digit 0 always shows.
- error is never asserted outside IDLE; overflow is cleared only by reset or clearScore.

Test Plan:
- Reset, then add 0x25 with SCORE_DIGITS=6: ready low for 7 cycles, then score=0x000025, highScore=0x000025, display digits 0-1 = "5","2", digits 2-5 = 7'h7F.
- Score 0x000095 + addend 0x07: carry ripple gives score=0x000102 exactly 7 cycles after accept; overflow=0.
- Score 0x999990 + addend 0x15: score=0x999999, overflow=1. A further add of 0x01 keeps 0x999999 and overflow=1.
- Addend 0x3A with enable in IDLE: error pulses one cycle, ready stays 1, score unchanged.
- Score 0x000050, clearScore pulsed during ADD cycle 3: score=0, state IDLE the next cycle, highScore stays 0x000050. showHigh=1 shows "50" one cycle later.
- enable and clearScore asserted together: no accept, score=0. reset=0 asserted mid-ADD: all outputs return to their reset values at the next edge.
